// File: rtl/rvc_mem_arb_5pl.sv
// Shares the single data-memory port between the core's Q103H load/store stage
// and a host debug/loader port, with a bounded-starvation guarantee for the host.
module rvc_mem_arb_5pl #(
  parameter int MAX_CORE_CONSEC = 4,
  parameter int CNT_W           = 4
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        CoreReqQ103H,
  input  logic        CoreWrEnQ103H,
  input  logic [31:0] CoreAddrQ103H,
  input  logic [31:0] CoreWrDataQ103H,
  input  logic [3:0]  CoreByteEnQ103H,
  output logic        CoreStall,
  input  logic        HostReq,
  input  logic        HostWrEn,
  input  logic [31:0] HostAddr,
  input  logic [31:0] HostWrData,
  input  logic [3:0]  HostByteEn,
  output logic        HostAck,
  output logic [31:0] HostRdData,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWrData,
  output logic [3:0]  MemByteEn,
  output logic        MemWrEn,
  output logic        MemRdEn,
  input  logic [31:0] MemRdData
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HOST_ACC = 2'd1;
  localparam logic [1:0] HOST_ACK = 2'd2;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CORE_CONSEC);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_q, rd_d;
  logic             wr_en;
  logic             core_grant;

  // Host accesses are word-aligned; the low address bits carry no meaning.
  logic unused_addr;
  assign unused_addr = ^HostAddr[1:0];

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    MemAddr    = CoreAddrQ103H;
    MemWrData  = CoreWrDataQ103H;
    MemByteEn  = CoreByteEnQ103H;
    wr_en      = CoreReqQ103H & CoreWrEnQ103H;
    MemRdEn    = CoreReqQ103H & ~CoreWrEnQ103H;
    CoreStall  = 1'b0;
    core_grant = CoreReqQ103H;
    case (state_q)
      IDLE: begin
        if (HostReq && (!CoreReqQ103H || cnt_q == MAX_C)) state_d = HOST_ACC;
      end
      HOST_ACC: begin
        MemAddr    = {HostAddr[31:2], 2'b00};
        MemWrData  = HostWrData;
        MemByteEn  = HostWrEn ? HostByteEn : 4'hF;
        wr_en      = HostWrEn;
        MemRdEn    = ~HostWrEn;
        CoreStall  = CoreReqQ103H;
        core_grant = 1'b0;
        rd_d       = HostWrEn ? 32'h0 : MemRdData;
        state_d    = HOST_ACK;
      end
      // HostReq deliberately ignored here so the core always gets one slot.
      HOST_ACK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!HostReq || (state_q == IDLE && state_d == HOST_ACC)) cnt_d = '0;
    else if (core_grant && cnt_q != MAX_C)                    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  assign MemWrEn    = wr_en & ~Rst;
  assign HostAck    = (state_q == HOST_ACK);
  assign HostRdData = rd_q;

endmodule

// File: tb/tb_rvc_mem_arb_5pl.sv
// Directed bench for rvc_mem_arb_5pl: a cycle table plus hand sequences for
// starvation limit, stalled-store replay and reset during a host access.
module tb_rvc_mem_arb_5pl;

  logic        clk = 1'b0;
  logic        rst;
  logic        creq, cwe;
  logic [31:0] caddr, cwd;
  logic [3:0]  cbe;
  logic        stall;
  logic        hreq, hwe;
  logic [31:0] haddr, hwd;
  logic [3:0]  hbe;
  logic        hack;
  logic [31:0] hrd;
  logic [31:0] maddr, mwd, mrd;
  logic [3:0]  mbe;
  logic        mwe, mre;

  int n_tot  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rvc_mem_arb_5pl #(.MAX_CORE_CONSEC(4), .CNT_W(4)) dut (
    .Clock(clk), .Rst(rst),
    .CoreReqQ103H(creq), .CoreWrEnQ103H(cwe), .CoreAddrQ103H(caddr),
    .CoreWrDataQ103H(cwd), .CoreByteEnQ103H(cbe), .CoreStall(stall),
    .HostReq(hreq), .HostWrEn(hwe), .HostAddr(haddr), .HostWrData(hwd),
    .HostByteEn(hbe), .HostAck(hack), .HostRdData(hrd),
    .MemAddr(maddr), .MemWrData(mwd), .MemByteEn(mbe), .MemWrEn(mwe),
    .MemRdEn(mre), .MemRdData(mrd)
  );

  // Memory wrapper model: async read, byte-enabled synchronous write.
  logic [31:0] mem [0:4095];
  assign mrd = mem[maddr[13:2]];
  always @(posedge clk)
    if (mwe)
      for (int b = 0; b < 4; b++)
        if (mbe[b]) mem[maddr[13:2]][8*b +: 8] <= mwd[8*b +: 8];

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic [3:0]  cbe;
    logic        hreq, hwe;
    logic [31:0] haddr, hwd;
    logic [3:0]  hbe;
    logic        stall, ack, mwe, mre;
    logic [31:0] maddr, mwd;
    logic [3:0]  mbe;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(
    input logic creq, cwe, input logic [31:0] caddr, cwd, input logic [3:0] cbe,
    input logic hreq, hwe, input logic [31:0] haddr, hwd, input logic [3:0] hbe,
    input logic stall, ack, mwe, mre, input logic [31:0] maddr, mwd,
    input logic [3:0] mbe, input logic [31:0] rd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd; v.cbe = cbe;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd; v.hbe = hbe;
    v.stall = stall; v.ack = ack; v.mwe = mwe; v.mre = mre;
    v.maddr = maddr; v.mwd = mwd; v.mbe = mbe; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    creq = v.creq; cwe = v.cwe; caddr = v.caddr; cwd = v.cwd; cbe = v.cbe;
    hreq = v.hreq; hwe = v.hwe; haddr = v.haddr; hwd = v.hwd; hbe = v.hbe;
  endtask

  task automatic chk_vec(input vec_t v, input string tag);
    chk({tag, ".stall"}, 32'(stall), 32'(v.stall));
    chk({tag, ".ack"},   32'(hack),  32'(v.ack));
    chk({tag, ".mwe"},   32'(mwe),   32'(v.mwe));
    chk({tag, ".mre"},   32'(mre),   32'(v.mre));
    if (v.ack) chk({tag, ".rd"}, hrd, v.rd);
    if (v.mwe || v.mre) begin
      chk({tag, ".maddr"}, maddr, v.maddr);
      chk({tag, ".mbe"},   32'(mbe), 32'(v.mbe));
    end
    if (v.mwe) chk({tag, ".mwd"}, mwd, v.mwd);
  endtask

  // Drive on the falling edge, compare 2 time units later (3 before the rising edge).
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #2;
    chk_vec(v, tag);
  endtask

  task automatic starve(input string tag);
    for (int k = 0; k < 5; k++)
      step(mk(1,0,32'h100+32'(4*k),0,4'hF, 1,0,32'h3000,0,4'hF,
              0,0,0,1,32'h100+32'(4*k),0,4'hF,0), $sformatf("%s.c%0d", tag, k));
    step(mk(1,0,32'h114,0,4'hF, 1,0,32'h3000,0,4'hF, 1,0,0,1,32'h3000,0,4'hF,0), {tag, ".c5"});
    step(mk(1,0,32'h114,0,4'hF, 0,0,0,0,0, 0,1,0,1,32'h114,0,4'hF,32'hA5A50F0F), {tag, ".c6"});
    step(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0), {tag, ".c7"});
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0);
    // Core pass-through
    tbl.push_back(idle);
    tbl.push_back(mk(1,0,32'h40,0,4'hF, 0,0,0,0,0, 0,0,0,1,32'h40,0,4'hF,0));
    tbl.push_back(mk(1,1,32'h44,32'h55,4'h3, 0,0,0,0,0, 0,0,1,0,32'h44,32'h55,4'h3,0));
    // Host write 0x1003 -> word 0x1000; HostReq still high during ack is ignored
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h1003,32'hDEADBEEF,4'hF, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h1003,32'hDEADBEEF,4'hF, 0,0,1,0,32'h1000,32'hDEADBEEF,4'hF,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h1003,32'hDEADBEEF,4'hF, 0,1,0,0,0,0,0,0));
    tbl.push_back(idle);
    // Host write 0x3000
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h3000,32'hA5A50F0F,4'hF, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h3000,32'hA5A50F0F,4'hF, 0,0,1,0,32'h3000,32'hA5A50F0F,4'hF,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,1,0,0,0,0,0,0));
    tbl.push_back(idle);
    // Host read-back of 0x1000
    tbl.push_back(mk(0,0,0,0,0, 1,0,32'h1000,0,4'hF, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,32'h1000,0,4'hF, 0,0,0,1,32'h1000,0,4'hF,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,1,0,0,0,0,0,32'hDEADBEEF));
    tbl.push_back(idle);
    // Host read with partial enables and unaligned address: full word returned
    tbl.push_back(mk(0,0,0,0,0, 1,0,32'h3002,0,4'h1, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,32'h3002,0,4'h1, 0,0,0,1,32'h3000,0,4'hF,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,1,0,0,0,0,0,32'hA5A50F0F));
    tbl.push_back(idle);
    // Back-to-back host reads, HostReq held: grants at 1,4,7, acks at 2,5,8
    for (int r = 0; r < 3; r++) begin
      tbl.push_back(mk(0,0,0,0,0, 1,0,32'h3000,0,4'hF, 0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0, 1,0,32'h3000,0,4'hF, 0,0,0,1,32'h3000,0,4'hF,0));
      tbl.push_back(mk(0,0,0,0,0, 1,0,32'h3000,0,4'hF, 0,1,0,0,0,0,0,32'hA5A50F0F));
    end
    tbl.push_back(idle);

    rst = 1'b1;
    drive(idle);
    #2;
    chk("reset.ack",   32'(hack),  32'h0);
    chk("reset.rd",    hrd,        32'h0);
    chk("reset.stall", 32'(stall), 32'h0);
    chk("reset.mwe",   32'(mwe),   32'h0);
    chk("reset.mre",   32'(mre),   32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Core store arriving while host owns the port is replayed next cycle
    step(mk(0,0,0,0,0, 1,1,32'h1000,32'hDEADBEEF,4'hF, 0,0,0,0,0,0,0,0), "replay.req");
    step(mk(1,1,32'h2000,32'h11223344,4'h3, 1,1,32'h1000,32'hDEADBEEF,4'hF,
            1,0,1,0,32'h1000,32'hDEADBEEF,4'hF,0), "replay.acc");
    step(mk(1,1,32'h2000,32'h11223344,4'h3, 0,0,0,0,0,
            0,1,1,0,32'h2000,32'h11223344,4'h3,0), "replay.ack");
    step(idle, "replay.idle");

    starve("starve");

    // Reset pulsed during HOST_ACC of a host write
    step(mk(0,0,0,0,0, 1,1,32'h1000,32'h12345678,4'hF, 0,0,0,0,0,0,0,0), "rstacc.req");
    @(negedge clk);
    drive(mk(0,0,0,0,0, 1,1,32'h1000,32'h12345678,4'hF, 0,0,0,0,0,0,0,0));
    #1 rst = 1'b1;
    #1;
    chk("rstacc.mwe", 32'(mwe),  32'h0);
    chk("rstacc.ack", 32'(hack), 32'h0);
    chk("rstacc.rd",  hrd,       32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(idle);
    #2;
    chk("rstacc.noack", 32'(hack), 32'h0);
    step(idle, "rstacc.idle");
    step(mk(0,0,0,0,0, 1,0,32'h1000,0,4'hF, 0,0,0,0,0,0,0,0), "rstrd.req");
    step(mk(0,0,0,0,0, 1,0,32'h1000,0,4'hF, 0,0,0,1,32'h1000,0,4'hF,0), "rstrd.acc");
    step(mk(0,0,0,0,0, 0,0,0,0,0, 0,1,0,0,0,0,0,32'hDEADBEEF), "rstrd.ack");
    step(idle, "rstrd.idle");

    starve("starve2");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rvc_mem_arb_5pl.md
Name: rvc_mem_arb_5pl

Overview:
Arbiter and sequencer that shares the single data-memory access port between the core's Q103H load/store stage and an external host port. The host port is used by a debug/loader path to read and write I_MEM/D_MEM without backdoor forcing. The block sits between the pipeline's memory stage and the memory wrapper. It drives the wrapper's address, write-data, byte-enable and write/read enables, and stalls the core when the host owns the port.

Parameters:
MAX_CORE_CONSEC, 4, consecutive core grants allowed while a host request is pending before the host is forced in (1..15)
CNT_W, 4, width of the consecutive-grant counter

Ports:
Clock  in  1  core clock, all state on rising edge
Rst  in  1  asynchronous, active-high reset
CoreReqQ103H  in  1  core memory access valid (load or store)
CoreWrEnQ103H  in  1  1 = store, 0 = load
CoreAddrQ103H  in  32  core byte address
CoreWrDataQ103H  in  32  core store data
CoreByteEnQ103H  in  4  core byte enables
CoreStall  out  1  core must hold Q103H and all earlier stages this cycle
HostReq  in  1  host access request; level, held until HostAck
HostWrEn  in  1  1 = write, 0 = read
HostAddr  in  32  host byte address; bits [1:0] ignored (word access)
HostWrData  in  32  host write data
HostByteEn  in  4  host write byte enables (reads return full word)
HostAck  out  1  one-cycle completion pulse
HostRdData  out  32  read data, valid only while HostAck=1
MemAddr  out  32  to memory wrapper
MemWrData  out  32  to memory wrapper
MemByteEn  out  4  to memory wrapper
MemWrEn  out  1  to memory wrapper
MemRdEn  out  1  to memory wrapper
MemRdData  in  32  asynchronous read data for the current MemAddr

Behaviour:
- Reset (async, Rst=1): state IDLE, counter=0, HostAck=0, HostRdData=0. CoreStall, MemWrEn and MemRdEn are 0 whenever no request is present.
- States:
  - IDLE: core has the port.
  - HOST_ACC: host owns the port this cycle.
  - HOST_ACK: completion cycle.
- IDLE:
  - Core request present: pass through combinationally. MemAddr=CoreAddrQ103H, MemWrData=CoreWrDataQ103H, MemByteEn=CoreByteEnQ103H, MemWrEn=CoreWrEnQ103H, MemRdEn=~CoreWrEnQ103H. CoreStall=0.
  - Go to HOST_ACC when HostReq=1 and either (a) CoreReqQ103H=0, or (b) counter==MAX_CORE_CONSEC. In case (b) this cycle still serves the core; the host is granted next cycle.
- Counter:
  - Increments (saturating at MAX_CORE_CONSEC) on each core grant while HostReq=1.
  - Clears on entry to HOST_ACC and whenever HostReq=0.
- HOST_ACC:
  - MemAddr={HostAddr[31:2],2'b00}, MemWrData=HostWrData.
  - MemByteEn=HostByteEn when writing, 4'hF when reading.
  - MemWrEn=HostWrEn, MemRdEn=~HostWrEn.
  - MemRdData is registered into HostRdData at the rising edge.
  - CoreStall=CoreReqQ103H.
  - Next state is HOST_ACK unconditionally.
- HOST_ACK:
  - HostAck=1; HostRdData holds the sampled value (writes: value is don't-care, implement as 0).
  - Core owns the port as in IDLE; CoreStall=0.
  - HostReq is ignored this cycle, so a back-to-back host request cannot re-grant before the core gets one slot.
  - Next state is IDLE.
- Latency and throughput:
  - Idle port: HostReq rises at cycle N, grant at N+1, HostAck at N+2.
  - Maximum host throughput: one access per 3 cycles (IDLE, HOST_ACC, HOST_ACK).
- Host must keep HostAddr, HostWrData, HostByteEn and HostWrEn stable from HostReq rise until HostAck. Deasserting HostReq while in HOST_ACC does not abort the access; it completes and is acked.
- Core stall rules:
  - The core stalls only in HOST_ACC.
  - A stalled core request is served in the following HOST_ACK cycle with unchanged inputs.
- Rst asserted mid-access: the access is dropped, HostAck is not issued, and any memory write in that cycle is suppressed (MemWrEn gated by ~Rst).
- No address-range checking; range decode belongs to the memory wrapper.

Test Plan:
1. Host write only: HostReq=1, HostWrEn=1, HostAddr=0x0000_1003, HostWrData=0xDEAD_BEEF, HostByteEn=4'hF, core idle.
   -> MemAddr=0x1000 and MemWrEn=1 at N+1; HostAck=1 at N+2; a later host read of 0x1000 returns HostRdData=0xDEAD_BEEF with HostAck.
2. Starvation limit: core requests every cycle, HostReq held from cycle 0, MAX_CORE_CONSEC=4.
   -> Core served cycles 0-4; HOST_ACC at cycle 5 with CoreStall=1; HostAck and core served at 6; CoreStall=0 at 6.
3. Back-to-back host: HostReq kept high after HostAck, core idle.
   -> Grants at cycles 1, 4, 7; HostAck at 2, 5, 8; never two consecutive HostAck cycles.
4. Stalled store replay: core store Addr=0x2000, Data=0x11223344, ByteEn=4'b0011 arrives during HOST_ACC.
   -> CoreStall=1 that cycle; MemWrEn=1 with MemByteEn=4'b0011, MemAddr=0x2000 on the next cycle.
5. Reset mid-access: Rst pulsed during HOST_ACC of a host write.
   -> MemWrEn=0 that cycle, HostAck never pulses, state IDLE, HostRdData=0, counter=0.
6. Host read, partial enables: HostByteEn=4'b0001, HostWrEn=0, memory word 0xA5A5_0F0F.
   -> MemByteEn=4'hF, MemRdEn=1, HostRdData=0xA5A5_0F0F with HostAck.
